// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period, bus status layout, receiver FSM encoding.
package uart_pkg;

  // 6 MHz bus clock / 625 = 9600 baud; shared with uart_tx
  localparam int PRESCALER_DEFAULT = 625;

  // Bus read word layout
  localparam int DATA_LSB  = 0;
  localparam int DATA_MSB  = 7;
  localparam int VALID_BIT = 8;
  localparam int FERR_BIT  = 9;
  localparam int OVR_BIT   = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rxState_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous pin; reset value selects the pin's idle level.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic BusClk,
  input  logic BusRst,
  input  logic AsyncIn,
  output logic SyncOut
);

  logic meta_p0;
  logic sync_p1;

  // Two back-to-back flops; the first may go metastable, the second gives a settled level
  always_ff @(posedge BusClk) begin
    if (BusRst) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      meta_p0 <= AsyncIn;
      sync_p1 <= meta_p0;
    end
  end

  assign SyncOut = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deserialises 8N1 frames into a one-byte holding register with status flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int PRESCALER = PRESCALER_DEFAULT,
  parameter int HALF      = PRESCALER / 2
) (
  input  logic        BusClk,
  input  logic        BusRst,
  input  logic        BusRd,
  output logic [31:0] BusData,
  input  logic        PhyIn
);

  localparam logic [11:0] HALF_LAST = 12'(HALF - 1);
  localparam logic [11:0] BIT_LAST  = 12'(PRESCALER - 1);

  logic       rx;
  rxState_t   state, stateNext;
  logic [11:0] pCnt, pCntNext;
  logic [2:0] bitCnt, bitCntNext;
  logic [7:0] shiftReg;
  logic       shiftEn;
  logic       byteDone;
  logic       ferrEvent;
  logic [7:0] dataReg;
  logic       valid;
  logic       ferr;
  logic       ovr;

  uart_sync #(.RESET_VAL(1'b1)) uSync (
    .BusClk  (BusClk),
    .BusRst  (BusRst),
    .AsyncIn (PhyIn),
    .SyncOut (rx)
  );

  // FSM state and bit-timing counters
  always_ff @(posedge BusClk) begin
    if (BusRst) begin
      state  <= IDLE;
      pCnt   <= '0;
      bitCnt <= '0;
    end else begin
      state  <= stateNext;
      pCnt   <= pCntNext;
      bitCnt <= bitCntNext;
    end
  end

  // Next state, counter updates and sample-point strobes; samples land at mid-bit
  always_comb begin
    stateNext  = state;
    pCntNext   = pCnt;
    bitCntNext = bitCnt;
    shiftEn    = 1'b0;
    byteDone   = 1'b0;
    ferrEvent  = 1'b0;
    case (state)
      IDLE: begin
        pCntNext = '0;
        if (!rx) stateNext = START;
      end
      START: begin
        if (pCnt == HALF_LAST) begin
          pCntNext   = '0;
          bitCntNext = '0;
          // A start bit that is high again at mid-bit was a glitch
          stateNext  = rx ? IDLE : DATA;
        end else begin
          pCntNext = pCnt + 12'd1;
        end
      end
      DATA: begin
        if (pCnt == BIT_LAST) begin
          pCntNext   = '0;
          shiftEn    = 1'b1;
          bitCntNext = bitCnt + 3'd1;
          if (bitCnt == 3'd7) stateNext = STOP;
        end else begin
          pCntNext = pCnt + 12'd1;
        end
      end
      STOP: begin
        if (pCnt == BIT_LAST) begin
          pCntNext = '0;
          if (rx) begin
            byteDone  = 1'b1;
            stateNext = IDLE;
          end else begin
            ferrEvent = 1'b1;
            stateNext = BREAK;
          end
        end else begin
          pCntNext = pCnt + 12'd1;
        end
      end
      BREAK: begin
        // Hold here while the line stays low so a break reports one error only
        pCntNext = '0;
        if (rx) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // LSB-first shift: each sample enters at bit 7 and moves right
  always_ff @(posedge BusClk) begin
    if (shiftEn) shiftReg <= {rx, shiftReg[7:1]};
  end

  // Holding register and status flags; a new event takes priority over a read
  always_ff @(posedge BusClk) begin
    if (BusRst) begin
      dataReg <= '0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (byteDone) begin
        dataReg <= shiftReg;
        valid   <= 1'b1;
        ovr     <= BusRd ? 1'b0 : (ovr | valid);
      end else if (BusRd) begin
        valid <= 1'b0;
        ovr   <= 1'b0;
      end
      if (ferrEvent) ferr <= 1'b1;
      else if (BusRd) ferr <= 1'b0;
    end
  end

  // Read word built only from flops, so no input reaches BusData combinationally
  always_comb begin
    BusData                    = '0;
    BusData[DATA_MSB:DATA_LSB] = dataReg;
    BusData[VALID_BIT]         = valid;
    BusData[FERR_BIT]          = ferr;
    BusData[OVR_BIT]           = ovr;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a short bit period.
module tb_uart_rx;

  localparam int P = 16;

  logic        BusClk;
  logic        BusRst;
  logic        BusRd;
  logic [31:0] BusData;
  logic        PhyIn;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frameStart = 0;
  int riseCyc = -1;
  logic prevValid = 1'b0;

  uart_rx #(.PRESCALER(P)) dut (
    .BusClk  (BusClk),
    .BusRst  (BusRst),
    .BusRd   (BusRd),
    .BusData (BusData),
    .PhyIn   (PhyIn)
  );

  initial BusClk = 1'b0;
  always #5 BusClk = ~BusClk;

  always @(posedge BusClk) cyc <= cyc + 1;

  // Remember the cycle in which Valid last rose
  always @(negedge BusClk) begin
    if (BusData[8] && !prevValid) riseCyc = cyc;
    prevValid = BusData[8];
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] exp);
    total++;
    assert (BusData === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, BusData, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic waitCyc(input int n);
    repeat (n) @(posedge BusClk);
    #1;
  endtask

  task automatic driveBit(input logic v);
    PhyIn = v;
    waitCyc(P);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    frameStart = cyc;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(stopBit);
  endtask

  task automatic doRead();
    BusRd = 1'b1;
    waitCyc(1);
    BusRd = 1'b0;
  endtask

  // Raise BusRd for exactly the edge on which the stop bit is sampled
  task automatic readAtStop();
    waitCyc(154);
    BusRd = 1'b1;
    waitCyc(1);
    BusRd = 1'b0;
  endtask

  initial begin
    BusRst = 1'b1;
    BusRd  = 1'b0;
    PhyIn  = 1'b1;
    waitCyc(3);
    check("reset", 32'h0000_0000);
    BusRst = 1'b0;
    waitCyc(2);

    // Basic frame: pin driven low before edge frameStart+1; Valid 154 cycles after that edge
    sendFrame(8'hA5, 1'b1);
    checkInt("latencyA5", riseCyc - frameStart, 155);
    check("frameA5", 32'h0000_01A5);
    doRead();
    check("readA5", 32'h0000_00A5);

    // Short low glitch is rejected at the start-bit mid-sample
    PhyIn = 1'b0;
    waitCyc(5);
    PhyIn = 1'b1;
    waitCyc(2 * P);
    check("glitch", 32'h0000_00A5);
    sendFrame(8'h3C, 1'b1);
    check("after_glitch", 32'h0000_013C);
    doRead();
    check("read3C", 32'h0000_003C);

    // Two bytes without a read: overrun, second byte kept
    sendFrame(8'h11, 1'b1);
    check("first11", 32'h0000_0111);
    sendFrame(8'h22, 1'b1);
    check("overrun", 32'h0000_0522);
    doRead();
    check("read_ovr", 32'h0000_0022);

    // Stop bit low then line held low: one frame error, data untouched
    sendFrame(8'h55, 1'b0);
    check("ferr", 32'h0000_0222);
    waitCyc(20 * P);
    check("ferr_hold", 32'h0000_0222);
    doRead();
    check("ferr_read", 32'h0000_0022);
    waitCyc(20 * P);
    check("break_single", 32'h0000_0022);
    PhyIn = 1'b1;
    waitCyc(P);

    // Frame error stays set across a later good byte until read
    sendFrame(8'h99, 1'b0);
    waitCyc(2 * P);
    PhyIn = 1'b1;
    waitCyc(P);
    check("ferr2", 32'h0000_0222);
    sendFrame(8'h7E, 1'b1);
    check("ferr_plus7E", 32'h0000_037E);
    doRead();
    check("read7E", 32'h0000_007E);

    // Read on the completion edge of a second byte: no overrun
    sendFrame(8'h44, 1'b1);
    check("first44", 32'h0000_0144);
    fork
      sendFrame(8'h5A, 1'b1);
      readAtStop();
    join
    check("rd_at_done", 32'h0000_015A);

    // Read on the frame-error edge: error wins, Valid cleared
    fork
      sendFrame(8'h66, 1'b0);
      readAtStop();
    join
    check("rd_at_ferr", 32'h0000_025A);
    PhyIn = 1'b1;
    waitCyc(P);
    doRead();
    check("read5A", 32'h0000_005A);

    // Reset in the middle of data bit 4 (0xC3 has bit4 = 0, line low)
    PhyIn = 1'b0;
    waitCyc(P);
    driveBit(1'b1);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b0);
    PhyIn = 1'b0;
    waitCyc(P / 2);
    BusRst = 1'b1;
    PhyIn  = 1'b1;
    waitCyc(1);
    check("mid_reset", 32'h0000_0000);
    BusRst = 1'b0;
    waitCyc(2 * P);
    check("post_reset_idle", 32'h0000_0000);
    sendFrame(8'h81, 1'b1);
    checkInt("latency81", riseCyc - frameStart, 155);
    check("frame81", 32'h0000_0181);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
